// File: rtl/mac_arbiter.sv
// -----------------------------------------------------------------------------
// mac_arbiter
//
// Purpose:
//   Two-requester round-robin arbiter in front of a single two-stage
//   multiply-accumulate engine. A granted requester streams LEN operand pairs
//   (x, y) with a valid/ready handshake. The MAC registers x*y at the accept
//   edge and adds that product into the accumulator on the following edge.
//   Two DRAIN cycles flush the final product, then a one-cycle DONE strobe
//   presents the 32-bit result and the owning requester id.
//
// Build option:
//   MAC_SAT_EN  defined   -> accumulator saturates at 32'hFFFF_FFFF and stays
//                            there for the rest of the job.
//               undefined -> accumulator wraps modulo 2^32.
//   The port list is identical in both builds.
//
// Parameters:
//   LEN_W        width of the per-job operand pair count.
//
// Ports:
//   i_Clk        clock; all state updates on the rising edge.
//   i_Rst        asynchronous active-high reset; aborts any job in flight.
//   i_req_N      job request from requester N (sampled only in IDLE).
//   i_len_N      pair count of requester N's job (latched on grant).
//   i_x_N/i_y_N  16-bit unsigned operands from requester N.
//   i_valid_N    operand pair from requester N is valid.
//   o_grant_N    requester N owns the MAC (grant edge through DONE).
//   o_ready_N    the MAC accepts a pair from requester N this cycle.
//   o_sum        result of the most recent job; holds until the next DONE.
//   o_done       one-cycle result strobe.
//   o_done_id    requester that owns o_sum.
// -----------------------------------------------------------------------------
module mac_arbiter #(
    parameter int LEN_W = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_req_0,
    input  logic             i_req_1,
    input  logic [LEN_W-1:0] i_len_0,
    input  logic [LEN_W-1:0] i_len_1,
    input  logic [15:0]      i_x_0,
    input  logic [15:0]      i_y_0,
    input  logic [15:0]      i_x_1,
    input  logic [15:0]      i_y_1,
    input  logic             i_valid_0,
    input  logic             i_valid_1,
    output logic             o_grant_0,
    output logic             o_grant_1,
    output logic             o_ready_0,
    output logic             o_ready_1,
    output logic [31:0]      o_sum,
    output logic             o_done,
    output logic             o_done_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // Job context
    logic             r_owner;       // requester currently holding the MAC
    logic             r_last_grant;  // requester granted most recently
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;         // pairs accepted so far
    logic             r_drain;       // second DRAIN cycle marker

    // MAC pipeline
    logic [31:0]      r_prod;
    logic [31:0]      r_acc;

    // Result registers
    logic [31:0]      r_sum;
    logic             r_done_id;

    // Combinational control
    logic             w_grant_en;
    logic             w_win_id;
    logic [LEN_W-1:0] w_win_len;
    logic             w_accept;
    logic [LEN_W-1:0] w_cnt_inc;
    logic [15:0]      w_x;
    logic [15:0]      w_y;
    logic [31:0]      w_prod;
    logic [31:0]      w_acc_sum;

    assign w_cnt_inc = r_cnt + LEN_W'(1);
    assign w_x       = r_owner ? i_x_1 : i_x_0;
    assign w_y       = r_owner ? i_y_1 : i_y_0;
    assign w_prod    = 32'(w_x) * 32'(w_y);

`ifdef MAC_SAT_EN
    // Carry out of the 33-bit sum means the true total exceeded 2^32-1.
    // Once pinned at all-ones, any further add carries again, so the value
    // holds for the remainder of the job without extra state.
    logic [32:0]      w_acc_wide;
    assign w_acc_wide = {1'b0, r_acc} + {1'b0, r_prod};
    assign w_acc_sum  = w_acc_wide[32] ? '1 : w_acc_wide[31:0];
`else
    assign w_acc_sum  = r_acc + r_prod;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state, arbitration and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        w_win_id    = 1'b0;
        w_accept    = 1'b0;
        o_ready_0   = 1'b0;
        o_ready_1   = 1'b0;

        // Round-robin tie-break: with both requests present the requester
        // that was not granted last wins.
        if (i_req_0 && i_req_1) begin
            w_win_id = ~r_last_grant;
        end else begin
            w_win_id = i_req_1;
        end
        w_win_len = w_win_id ? i_len_1 : i_len_0;

        case (r_state)
            ST_IDLE: begin
                if (i_req_0 || i_req_1) begin
                    w_grant_en  = 1'b1;
                    w_state_nxt = (w_win_len == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                o_ready_0 = ~r_owner;
                o_ready_1 = r_owner;
                w_accept  = r_owner ? i_valid_1 : i_valid_0;
                if (w_accept && (w_cnt_inc == r_len)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Job context, MAC pipeline and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_len        <= '0;
            r_cnt        <= '0;
            r_drain      <= 1'b0;
            r_prod       <= '0;
            r_acc        <= '0;
            r_sum        <= '0;
            r_done_id    <= 1'b0;
        end else if (w_grant_en) begin
            r_owner      <= w_win_id;
            r_last_grant <= w_win_id;
            r_len        <= w_win_len;
            r_cnt        <= '0;
            r_drain      <= 1'b0;
            r_prod       <= '0;
            r_acc        <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // Accumulator always consumes the previous product; a
                    // bubble cycle loads a zero product so it adds nothing.
                    r_acc <= w_acc_sum;
                    if (w_accept) begin
                        r_prod <= w_prod;
                        r_cnt  <= w_cnt_inc;
                    end else begin
                        r_prod <= '0;
                    end
                end
                ST_DRAIN: begin
                    r_acc   <= w_acc_sum;
                    r_prod  <= '0;
                    r_drain <= ~r_drain;
                    // Last DRAIN edge: the final product was folded in on the
                    // previous edge, so w_acc_sum is the finished result.
                    if (r_drain) begin
                        r_sum     <= w_acc_sum;
                        r_done_id <= r_owner;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Grant spans every non-IDLE state, so it is a pure decode of the FSM.
    assign o_grant_0 = (r_state != ST_IDLE) && !r_owner;
    assign o_grant_1 = (r_state != ST_IDLE) && r_owner;
    assign o_done    = (r_state == ST_DONE);
    assign o_sum     = r_sum;
    assign o_done_id = r_done_id;

endmodule

// File: tb/tb_mac_arbiter.sv
module tb_mac_arbiter;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_0, req_1;
    logic [LEN_W-1:0] len_0, len_1;
    logic [15:0]      x_0, y_0, x_1, y_1;
    logic             valid_0, valid_1;
    logic             grant_0, grant_1, ready_0, ready_1;
    logic [31:0]      sum;
    logic             done, done_id;

    int checks = 0;
    int passed = 0;

    mac_arbiter #(.LEN_W(LEN_W)) dut (
        .i_Clk     (clk),
        .i_Rst     (rst),
        .i_req_0   (req_0),
        .i_req_1   (req_1),
        .i_len_0   (len_0),
        .i_len_1   (len_1),
        .i_x_0     (x_0),
        .i_y_0     (y_0),
        .i_x_1     (x_1),
        .i_y_1     (y_1),
        .i_valid_0 (valid_0),
        .i_valid_1 (valid_1),
        .o_grant_0 (grant_0),
        .o_grant_1 (grant_1),
        .o_ready_0 (ready_0),
        .o_ready_1 (ready_1),
        .o_sum     (sum),
        .o_done    (done),
        .o_done_id (done_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic test_reset;
        rst = 1'b1;
        req_0 = 0; req_1 = 0; len_0 = 0; len_1 = 0;
        x_0 = 0; y_0 = 0; x_1 = 0; y_1 = 0; valid_0 = 0; valid_1 = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({grant_0, grant_1, ready_0, ready_1, done, done_id} !== 6'b0)
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {grant_0, grant_1, ready_0, ready_1, done, done_id});
        else passed++;
        checks++;
        if (sum !== 32'd0) $display("FAIL reset_sum: got %h expected 0", sum);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({grant_0, grant_1, done} !== 3'b0)
            $display("FAIL idle_no_req: got %b expected 000", {grant_0, grant_1, done});
        else passed++;
    endtask

    // req0, len=3, pairs (2,3),(4,5),(6,7) back-to-back -> 68
    task automatic test_single;
        int xs[3] = '{2, 4, 6};
        int ys[3] = '{3, 5, 7};
        req_0 = 1; len_0 = 3;
        @(negedge clk);
        req_0 = 0;
        checks++;
        if ({grant_0, grant_1, ready_0, ready_1} !== 4'b1010)
            $display("FAIL single_grant: got %b expected 1010",
                     {grant_0, grant_1, ready_0, ready_1});
        else passed++;
        for (int i = 0; i < 3; i++) begin
            valid_0 = 1; x_0 = 16'(xs[i]); y_0 = 16'(ys[i]);
            @(negedge clk);
        end
        valid_0 = 0;
        for (int k = 1; k <= 2; k++) begin
            checks++;
            if ({done, ready_0} !== 2'b00)
                $display("FAIL single_early_done: cycle %0d got %b expected 00", k, {done, ready_0});
            else passed++;
            @(negedge clk);
        end
        checks++;
        if ({done, done_id, grant_0} !== 3'b101)
            $display("FAIL single_done: got %b expected 101", {done, done_id, grant_0});
        else passed++;
        checks++;
        if (sum !== 32'd68) $display("FAIL single_sum: got %0d expected 68", sum);
        else passed++;
        @(negedge clk);
        checks++;
        if ({done, grant_0, sum} !== {2'b00, 32'd68})
            $display("FAIL single_after: got done=%b grant=%b sum=%0d expected 0 0 68", done, grant_0, sum);
        else passed++;
    endtask

    // req1, len=2, valid 1,0,0,1 with (10,10),(5,5); bubble operands are junk
    task automatic test_bubbles;
        logic v[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   xs[4] = '{10, 999, 777, 5};
        req_1 = 1; len_1 = 2;
        @(negedge clk);
        req_1 = 0;
        checks++;
        if ({grant_0, grant_1} !== 2'b01)
            $display("FAIL bubble_grant: got %b expected 01", {grant_0, grant_1});
        else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ready_1 !== 1'b1) $display("FAIL bubble_ready: step %0d got %b expected 1", i, ready_1);
            else passed++;
            valid_1 = v[i]; x_1 = 16'(xs[i]); y_1 = 16'(xs[i]);
            @(negedge clk);
        end
        valid_1 = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({done, done_id} !== 2'b11)
            $display("FAIL bubble_done: got %b expected 11", {done, done_id});
        else passed++;
        checks++;
        if (sum !== 32'd125) $display("FAIL bubble_sum: got %0d expected 125", sum);
        else passed++;
        @(negedge clk);
    endtask

    // req0, len=0 -> sum 0, done 3 cycles after grant, ready never high
    task automatic test_zero_len;
        int seen_ready = 0;
        req_0 = 1; len_0 = 0;
        @(negedge clk);
        req_0 = 0;
        checks++;
        if (grant_0 !== 1'b1) $display("FAIL zero_grant: got %b expected 1", grant_0);
        else passed++;
        for (int k = 1; k <= 3; k++) begin
            if (ready_0 || ready_1) seen_ready++;
            if (k < 3) begin
                checks++;
                if (done !== 1'b0) $display("FAIL zero_early_done: cycle %0d got %b expected 0", k, done);
                else passed++;
                @(negedge clk);
            end
        end
        checks++;
        if ({done, done_id} !== 2'b10)
            $display("FAIL zero_done: got %b expected 10", {done, done_id});
        else passed++;
        checks++;
        if (sum !== 32'd0) $display("FAIL zero_sum: got %0d expected 0", sum);
        else passed++;
        checks++;
        if (seen_ready !== 0) $display("FAIL zero_ready: got %0d ready cycles expected 0", seen_ready);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_overflow;
        logic [31:0] exp_sum;
`ifdef MAC_SAT_EN
        exp_sum = 32'hFFFF_FFFF;
`else
        exp_sum = 32'hFFFC_0002;
`endif
        req_0 = 1; len_0 = 2;
        @(negedge clk);
        req_0 = 0;
        for (int i = 0; i < 2; i++) begin
            valid_0 = 1; x_0 = 16'hFFFF; y_0 = 16'hFFFF;
            @(negedge clk);
        end
        valid_0 = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1) $display("FAIL ovf_done: got %b expected 1", done);
        else passed++;
        checks++;
        if (sum !== exp_sum) $display("FAIL ovf_sum: got %h expected %h", sum, exp_sum);
        else passed++;
        @(negedge clk);
    endtask

    // Both requests held from reset -> grants 0,1,0, never overlapping
    task automatic test_round_robin;
        int order[3];
        int ngrant  = 0;
        int ndone   = 0;
        int overlap = 0;
        logic prev0 = 0, prev1 = 0;
        rst = 1;
        req_0 = 1; req_1 = 1; len_0 = 1; len_1 = 1;
        valid_0 = 1; valid_1 = 1; x_0 = 2; y_0 = 3; x_1 = 4; y_1 = 5;
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 60 && ndone < 3; c++) begin
            @(negedge clk);
            if (grant_0 && grant_1) overlap++;
            if (ngrant < 3 && grant_0 && !prev0) begin order[ngrant] = 0; ngrant++; end
            if (ngrant < 3 && grant_1 && !prev1) begin order[ngrant] = 1; ngrant++; end
            if (ngrant == 3) begin req_0 = 0; req_1 = 0; end
            if (done) begin
                checks++;
                if (sum !== (done_id ? 32'd20 : 32'd6))
                    $display("FAIL rr_sum: id %0d got %0d expected %0d", done_id, sum, done_id ? 20 : 6);
                else passed++;
                ndone++;
            end
            prev0 = grant_0; prev1 = grant_1;
        end
        valid_0 = 0; valid_1 = 0;
        checks++;
        if (ngrant !== 3 || ndone !== 3)
            $display("FAIL rr_count: got grants=%0d dones=%0d expected 3 3", ngrant, ndone);
        else passed++;
        checks++;
        if (ngrant == 3 && {order[0], order[1], order[2]} !== {32'd0, 32'd1, 32'd0})
            $display("FAIL rr_order: got %0d,%0d,%0d expected 0,1,0", order[0], order[1], order[2]);
        else if (ngrant == 3) passed++;
        else $display("FAIL rr_order: got %0d grants expected 0,1,0", ngrant);
        checks++;
        if (overlap !== 0) $display("FAIL rr_overlap: got %0d cycles expected 0", overlap);
        else passed++;
        @(negedge clk);
    endtask

    // Reset after 1 of 4 pairs aborts at once; then req0 len=1 (3,3) -> 9
    task automatic test_reset_mid_run;
        req_0 = 1; len_0 = 4;
        @(negedge clk);
        req_0 = 0;
        valid_0 = 1; x_0 = 7; y_0 = 7;
        @(negedge clk);
        valid_0 = 1; x_0 = 8; y_0 = 8;
        #2 rst = 1;
        #1;
        checks++;
        if ({grant_0, grant_1, ready_0, ready_1, done, done_id} !== 6'b0)
            $display("FAIL midrst_ctrl: got %b expected 000000",
                     {grant_0, grant_1, ready_0, ready_1, done, done_id});
        else passed++;
        checks++;
        if (sum !== 32'd0) $display("FAIL midrst_sum: got %h expected 0", sum);
        else passed++;
        valid_0 = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", done);
        else passed++;
        rst = 0;
        req_0 = 1; len_0 = 1;
        @(negedge clk);
        req_0 = 0;
        checks++;
        if ({grant_0, ready_0} !== 2'b11)
            $display("FAIL midrst_regrant: got %b expected 11", {grant_0, ready_0});
        else passed++;
        valid_0 = 1; x_0 = 3; y_0 = 3;
        @(negedge clk);
        valid_0 = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({done, done_id} !== 2'b10 || sum !== 32'd9)
            $display("FAIL midrst_result: got done=%b id=%b sum=%0d expected 1 0 9", done, done_id, sum);
        else passed++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_bubbles();
        test_zero_len();
        test_overflow();
        test_round_robin();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 SHALL have parameter LEN_W, default 8, meaning the width of the per-job pair count.
REQ-002 SHALL have port i_Clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port i_Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have ports i_req_0 and i_req_1, input, 1 bit each: job request from requester 0 and requester 1.
REQ-005 SHALL have ports i_len_0 and i_len_1, input, LEN_W bits each: number of operand pairs in the job.
REQ-006 SHALL have ports i_x_0, i_y_0, i_x_1 and i_y_1, input, 16 bits each: unsigned operands.
REQ-007 SHALL have ports i_valid_0 and i_valid_1, input, 1 bit each: the operand pair is valid.
REQ-008 SHALL have ports o_grant_0 and o_grant_1, output, 1 bit each: the requester owns the MAC.
REQ-009 SHALL have ports o_ready_0 and o_ready_1, output, 1 bit each: the MAC accepts a pair this cycle.
REQ-010 SHALL have port o_sum, output, 32 bits: job result.
REQ-011 SHALL have port o_done, output, 1 bit: one-cycle result strobe.
REQ-012 SHALL have port o_done_id, output, 1 bit: the requester owning the current o_sum.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-014 SHALL sample i_req_0 and i_req_1 only in IDLE; any other request activity SHALL be ignored.
REQ-015 In IDLE with exactly one request, SHALL grant that requester on the next edge.
REQ-016 In IDLE with both requests, SHALL grant the requester not granted last; last_grant resets to 1, so requester 0 wins first.
REQ-017 On grant, SHALL latch i_len of the winner, clear the pair counter, product register and accumulator, and go to RUN.
REQ-018 If the latched length is 0, SHALL go to DRAIN instead of RUN.
REQ-019 SHALL hold o_grant_N high from the grant edge through the DONE cycle inclusive; at most one grant SHALL be high at a time.
REQ-020 o_ready_N SHALL equal 1 only in RUN for the granted requester; a pair SHALL be accepted when i_valid_N && o_ready_N.
REQ-021 Cycles with i_valid low SHALL not be counted, and the operands in those cycles SHALL not be used.
REQ-022 Two-stage MAC: at the accept edge, product <= x*y, a full 32-bit unsigned product.
REQ-023 On the following edge, accumulator <= accumulator + product.
REQ-024 A bubble SHALL load product 0.
REQ-025 Accumulation SHALL wrap modulo 2^32.
REQ-026 At the edge accepting pair number len, SHALL go RUN->DRAIN.
REQ-027 DRAIN SHALL last exactly 2 cycles, so the final product is accumulated; the FSM SHALL then go to DONE.
REQ-028 DONE SHALL last exactly 1 cycle with o_done=1, after which the FSM SHALL return to IDLE.
REQ-029 o_sum and o_done_id SHALL update on entry to DONE and hold until the next DONE.
REQ-030 Latency: o_done SHALL be high in the 3rd cycle after the edge accepting the last pair.
REQ-031 Latency: for len=0, o_done SHALL be high in the 3rd cycle after the grant edge.
REQ-032 A request held through DONE SHALL be re-arbitrated in IDLE, with round-robin applied.

Reset
REQ-033 While i_Rst=1, SHALL force: state IDLE, o_grant_N=0, o_ready_N=0, o_done=0, o_done_id=0, o_sum=0, counter/product/accumulator=0, last_grant=1.
REQ-034 Reset asserted mid-job SHALL abort the job immediately with no o_done.
REQ-035 After release, the first edge SHALL behave as IDLE.

Configuration
REQ-036 Macro MAC_SAT_EN defined: accumulation SHALL saturate at 0xFFFFFFFF and hold there for the rest of the job.
REQ-037 Macro MAC_SAT_EN undefined: accumulation SHALL wrap per REQ-025.
REQ-038 The interface SHALL be identical in both builds.

Verification
REQ-039 Single job: req0, len=3, pairs (2,3),(4,5),(6,7) back-to-back -> o_sum=68, o_done_id=0, o_done 3 cycles after the 3rd accept.
REQ-040 Simultaneous: req0 and req1 both held from reset -> grant order 0,1,0; no cycle with both grants high.
REQ-041 Bubbles: req1, len=2, valid pattern 1,0,0,1 with pairs (10,10),(5,5) -> o_sum=125, o_done_id=1.
REQ-042 Zero length: req0, len=0 -> o_sum=0, o_done 3 cycles after grant, o_ready_0 never high.
REQ-043 Overflow: len=2, pairs (0xFFFF,0xFFFF) x2 -> o_sum=0xFFFC0002 without MAC_SAT_EN, 0xFFFFFFFF with it.
REQ-044 Reset mid-RUN after 1 of 4 pairs -> all outputs 0 at once; a following req0, len=1, pair (3,3) -> o_sum=9.
